// File: rtl/sgen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sgen_pkg -- phase-detector FSM state type and CORDIC arctangent table.
// Rev 1.0
// ---------------------------------------------------------------------------
package sgen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // atan(2^-i) as a fraction of a full circle, scaled to 2^32
   localparam logic [31:0] c_ATAN32 [32] = '{
      32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
      32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
      32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
      32'd166886,    32'd83443,     32'd41722,     32'd20861,
      32'd10430,     32'd5215,      32'd2608,      32'd1304,
      32'd652,       32'd326,       32'd163,       32'd81,
      32'd41,        32'd20,        32'd10,        32'd5,
      32'd3,         32'd1,         32'd1,         32'd0
   };

   // Table entry rescaled (rounded) to a full circle of 2^frac_bits, frac_bits <= 31.
   function automatic logic [31:0] atan_scaled(input logic [4:0] idx, input int unsigned frac_bits);
      logic [32:0] sum;
      sum = {1'b0, c_ATAN32[idx]} + (33'd1 << (31 - frac_bits));
      return sum[32:1] >> (31 - frac_bits);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sgen_cordic_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sgen_cordic_stage -- one vectoring-mode CORDIC micro-rotation (add/sub). Rev 1.0
// ---------------------------------------------------------------------------
module sgen_cordic_stage #(
   parameter int gp_xy_width = 19,
   parameter int gp_z_width  = 20,
   parameter int gp_sh_width = 4
) (
   input  logic signed [gp_xy_width-1:0] x_i,
   input  logic signed [gp_xy_width-1:0] y_i,
   input  logic        [gp_z_width-1:0]  z_i,
   input  logic        [gp_z_width-1:0]  atan_i,
   input  logic        [gp_sh_width-1:0] shift_i,
   output logic signed [gp_xy_width-1:0] x_o,
   output logic signed [gp_xy_width-1:0] y_o,
   output logic        [gp_z_width-1:0]  z_o
);

   logic signed [gp_xy_width-1:0] w_xs;
   logic signed [gp_xy_width-1:0] w_ys;

   assign w_xs = x_i >>> shift_i;
   assign w_ys = y_i >>> shift_i;

   always_comb begin
      if (!y_i[gp_xy_width-1]) begin
         x_o = x_i + w_ys;
         y_o = y_i - w_xs;
         z_o = z_i + atan_i;
      end else begin
         x_o = x_i - w_ys;
         y_o = y_i + w_xs;
         z_o = z_i - atan_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sgen_phase_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sgen_phase_det -- iterative CORDIC atan2 phase detector; SGEN_PHASE_DET_FCW_EN
// adds o_fcw (phase step between results). Rev 1.0
// ---------------------------------------------------------------------------
module sgen_phase_det
   import sgen_pkg::*;
#(
   parameter int gp_rom_width   = 8,
   parameter int gp_phase_width = 16,
   parameter int gp_iterations  = 14
) (
   input  logic                          i_clk,
   input  logic                          i_rst_an,
   input  logic                          i_ena,
   input  logic                          i_valid,
   input  logic signed [gp_rom_width:0]  i_sin,
   input  logic signed [gp_rom_width:0]  i_cos,
   output logic                          o_ready,
   output logic [gp_phase_width-1:0]     o_phase,
   output logic                          o_valid
`ifdef SGEN_PHASE_DET_FCW_EN
   ,
   output logic [gp_phase_width-1:0]     o_fcw
`endif
);

   // Fractional guard bits below the integer x/y and z ranges keep the
   // residual angle well under one output LSB.
   localparam int c_XY_GUARD = 8;
   localparam int c_Z_GUARD  = 4;
   localparam int c_XYW      = gp_rom_width + 3 + c_XY_GUARD;
   localparam int c_ZW       = gp_phase_width + c_Z_GUARD;
   localparam int c_CW       = $clog2(gp_iterations);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(gp_iterations - 1);

   state_t                    state_q, state_d;
   logic [c_CW-1:0]           cnt_q, cnt_d;
   logic signed [c_XYW-1:0]   x_q, x_d, y_q, y_d;
   logic [c_ZW-1:0]           z_q, z_d;
   logic [gp_phase_width-1:0] phase_q, phase_d;
   logic                      valid_q, valid_d;
   logic                      zero_q, zero_d;

   logic signed [c_XYW-1:0]   w_sin, w_cos, w_x_rot, w_y_rot;
   logic [c_ZW-1:0]           w_z_rot, w_atan;
   logic [gp_phase_width-1:0] w_phase_rnd;

   assign w_sin       = {{2{i_sin[gp_rom_width]}}, i_sin, {c_XY_GUARD{1'b0}}};
   assign w_cos       = {{2{i_cos[gp_rom_width]}}, i_cos, {c_XY_GUARD{1'b0}}};
   assign w_atan      = c_ZW'(atan_scaled(5'(cnt_q), c_ZW));
   assign w_phase_rnd = z_q[c_ZW-1:c_Z_GUARD] + gp_phase_width'(z_q[c_Z_GUARD-1]);

   sgen_cordic_stage #(
      .gp_xy_width (c_XYW),
      .gp_z_width  (c_ZW),
      .gp_sh_width (c_CW)
   ) u_stage (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .atan_i  (w_atan),
      .shift_i (cnt_q),
      .x_o     (w_x_rot),
      .y_o     (w_y_rot),
      .z_o     (w_z_rot)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      phase_d = phase_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      o_ready = (state_q == ST_IDLE);
      if (i_ena) begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  state_d = ST_ROTATE;
                  cnt_d   = '0;
                  zero_d  = (i_sin == '0) && (i_cos == '0);
                  // Left half-plane: rotate by 180 deg so the CORDIC converges.
                  if (i_cos[gp_rom_width]) begin
                     x_d = -w_cos;
                     y_d = -w_sin;
                     z_d = {1'b1, {(c_ZW-1){1'b0}}};
                  end else begin
                     x_d = w_cos;
                     y_d = w_sin;
                     z_d = '0;
                  end
               end
            end
            ST_ROTATE: begin
               x_d = w_x_rot;
               y_d = w_y_rot;
               z_d = w_z_rot;
               if (cnt_q == c_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + c_CW'(1);
               end
            end
            ST_DONE: begin
               phase_d = zero_q ? '0 : w_phase_rnd;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         phase_q <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
      end
   end

   assign o_phase = phase_q;
   assign o_valid = valid_q;

`ifdef SGEN_PHASE_DET_FCW_EN
   logic [gp_phase_width-1:0] prev_q, fcw_q;
   logic                      have_prev_q;

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         prev_q      <= '0;
         fcw_q       <= '0;
         have_prev_q <= 1'b0;
      end else if (valid_d) begin
         fcw_q       <= have_prev_q ? (phase_d - prev_q) : '0;
         prev_q      <= phase_d;
         have_prev_q <= 1'b1;
      end
   end

   assign o_fcw = fcw_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sgen_phase_det.sv
`default_nettype none
// Testbench for sgen_phase_det: axis/random phasors checked against a real-valued
// atan2 reference, plus throughput, reset-abort and enable-stall scenarios.
module tb_sgen_phase_det;

   localparam int  RW     = 8;
   localparam int  PW     = 16;
   localparam int  NI     = 14;
   localparam int  FULL   = 1 << PW;
   localparam real TWO_PI = 6.283185307179586;

   logic clk = 1'b0, rst_an = 1'b0, ena = 1'b0, valid = 1'b0;
   logic signed [RW:0] sin_in = '0, cos_in = '0;
   logic ready, vld;
   logic [PW-1:0] phase;
`ifdef SGEN_PHASE_DET_FCW_EN
   logic [PW-1:0] fcw;
`endif
   int n_vec = 0;
   int n_err = 0;

   sgen_phase_det #(
      .gp_rom_width   (RW),
      .gp_phase_width (PW),
      .gp_iterations  (NI)
   ) dut (
      .i_clk    (clk),
      .i_rst_an (rst_an),
      .i_ena    (ena),
      .i_valid  (valid),
      .i_sin    (sin_in),
      .i_cos    (cos_in),
      .o_ready  (ready),
      .o_phase  (phase),
      .o_valid  (vld)
`ifdef SGEN_PHASE_DET_FCW_EN
      ,
      .o_fcw    (fcw)
`endif
   );

   always #5 clk = ~clk;

   // Ideal atan2 phase, full circle = 2^PW, (0,0) -> 0.
   function automatic int ref_phase(input int s, input int c);
      real a;
      int  p;
      if (s == 0 && c == 0) return 0;
      a = $atan2(real'(s), real'(c));
      if (a < 0.0) a = a + TWO_PI;
      p = int'($floor(a / TWO_PI * real'(FULL) + 0.5));
      return p % FULL;
   endfunction

   function automatic int cdist(input int a, input int b);
      int d;
      d = ((a - b) % FULL + FULL) % FULL;
      return (d > FULL / 2) ? FULL - d : d;
   endfunction

   task automatic gen_pair(output int s, output int c);
      do begin
         s = int'($urandom_range(510)) - 255;
         c = int'($urandom_range(510)) - 255;
      end while ((s < 64 && s > -64) && (c < 64 && c > -64));
   endtask

   // Present one sample when ready, then wait (bounded) for its result.
   task automatic do_sample(input int s, input int c, output int ph, output int lat, output bit to);
      int k;
      to = 1'b1; lat = -1; ph = -1;
      for (k = 0; k < 50 && ready !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      if (ready !== 1'b1) return;
      sin_in = (RW+1)'(s);
      cos_in = (RW+1)'(c);
      valid  = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (vld === 1'b1) begin
            lat = n; ph = int'(phase); to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_an = 1'b0; ena = 1'b1; valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (ready !== 1'b1 || vld !== 1'b0 || phase !== '0) begin
         n_err++;
         $display("FAIL reset_hold: ready=%b valid=%b phase=%0d, required 1 0 0", ready, vld, phase);
      end
      rst_an = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (ready !== 1'b1 || vld !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b valid=%b, required 1 0", ready, vld);
      end
   endtask

   task automatic test_axes();
      int ts [5] = '{0, 255, 0, -255, 0};
      int tc [5] = '{255, 0, -256, 0, 0};
      int ph, lat, exp_ph, tol;
      bit to;
      for (int i = 0; i < 5; i++) begin
         exp_ph = ref_phase(ts[i], tc[i]);
         tol    = (ts[i] == 0 && tc[i] == 0) ? 0 : 2;
         do_sample(ts[i], tc[i], ph, lat, to);
         n_vec++;
         if (to || lat != NI + 1) begin
            n_err++;
            $display("FAIL axis_latency(%0d,%0d): got %0d cycles (timeout=%0b), required %0d", ts[i], tc[i], lat, to, NI + 1);
         end
         n_vec++;
         if (to || cdist(ph, exp_ph) > tol) begin
            n_err++;
            $display("FAIL axis_phase(%0d,%0d): got %0d, required %0d +-%0d", ts[i], tc[i], ph, exp_ph, tol);
         end
      end
   endtask

   task automatic test_random();
      int s, c, ph, lat, exp_ph;
      bit to;
      for (int i = 0; i < 16; i++) begin
         gen_pair(s, c);
         exp_ph = ref_phase(s, c);
         do_sample(s, c, ph, lat, to);
         n_vec++;
         if (to || lat != NI + 1 || cdist(ph, exp_ph) > 4) begin
            n_err++;
            $display("FAIL random(%0d,%0d): phase %0d lat %0d, required %0d +-4 lat %0d", s, c, ph, lat, exp_ph, NI + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int q_exp[$];
      int last_acc = -1;
      int s, c, e;
      valid = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         gen_pair(s, c);
         sin_in = (RW+1)'(s);
         cos_in = (RW+1)'(c);
         if (ready === 1'b1) begin
            if (last_acc >= 0) begin
               n_vec++;
               if (cyc - last_acc != NI + 2) begin
                  n_err++;
                  $display("FAIL b2b_spacing: got %0d cycles between accepts, required %0d", cyc - last_acc, NI + 2);
               end
            end
            last_acc = cyc;
            q_exp.push_back(ref_phase(s, c));
         end
         @(posedge clk); #1;
         if (vld === 1'b1) begin
            e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
            n_vec++;
            if (e < 0 || cdist(int'(phase), e) > 4) begin
               n_err++;
               $display("FAIL b2b_result: got %0d, required %0d +-4", phase, e);
            end
         end
      end
      valid = 1'b0;
      for (int cyc = 0; cyc < 20 && q_exp.size() > 0; cyc++) begin
         @(posedge clk); #1;
         if (vld === 1'b1) begin
            e = q_exp.pop_front();
            n_vec++;
            if (cdist(int'(phase), e) > 4) begin
               n_err++;
               $display("FAIL b2b_drain: got %0d, required %0d +-4", phase, e);
            end
         end
      end
      n_vec++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL b2b_missing: %0d results never arrived, required 0", q_exp.size());
      end
   endtask

   task automatic test_reset_mid();
      int spurious = 0;
      sin_in = 9'sd100; cos_in = -9'sd50; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_an = 1'b0;
      #1;
      n_vec++;
      if (phase !== '0 || vld !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_async: phase=%0d valid=%b, required 0 0", phase, vld);
      end
      @(posedge clk); #1;
      rst_an = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (ready !== 1'b1 || phase !== '0) begin
         n_err++;
         $display("FAIL rst_mid_release: ready=%b phase=%0d, required 1 0", ready, phase);
      end
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (vld === 1'b1) spurious++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (spurious != 0) begin
         n_err++;
         $display("FAIL rst_mid_abandon: got %0d o_valid pulses, required 0", spurious);
      end
   endtask

   task automatic test_ena_stall();
      int s, c, exp_ph, lat = -1, ph = -1, rdy_bad = 0, cyc = 0;
      gen_pair(s, c);
      exp_ph = ref_phase(s, c);
      sin_in = (RW+1)'(s); cos_in = (RW+1)'(c); valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1; cyc++;
      end
      ena = 1'b0;
      valid = 1'b1;
      repeat (10) begin
         @(posedge clk); #1; cyc++;
         if (ready !== 1'b0 || vld !== 1'b0) rdy_bad++;
      end
      valid = 1'b0;
      ena = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); #1; cyc++;
         if (vld === 1'b1) begin
            lat = cyc; ph = int'(phase);
            break;
         end
      end
      n_vec++;
      if (rdy_bad != 0) begin
         n_err++;
         $display("FAIL stall_frozen: %0d stalled cycles showed ready/valid high, required 0", rdy_bad);
      end
      n_vec++;
      if (lat != NI + 1 + 10) begin
         n_err++;
         $display("FAIL stall_latency: got %0d, required %0d", lat, NI + 11);
      end
      n_vec++;
      if (cdist(ph, exp_ph) > 4) begin
         n_err++;
         $display("FAIL stall_result(%0d,%0d): got %0d, required %0d +-4", s, c, ph, exp_ph);
      end
   endtask

`ifdef SGEN_PHASE_DET_FCW_EN
   task automatic test_fcw();
      int s, c, ph, lat, e, tol;
      bit to;
      real a;
      rst_an = 1'b0;
      @(posedge clk); #1;
      rst_an = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         a = (5000.0 + real'(k) * 16384.0) / real'(FULL) * TWO_PI;
         s = int'($floor(200.0 * $sin(a) + 0.5));
         c = int'($floor(200.0 * $cos(a) + 0.5));
         do_sample(s, c, ph, lat, to);
         e   = (k == 0) ? 0 : 16384;
         tol = (k == 0) ? 0 : 4;
         n_vec++;
         if (to || cdist(int'(fcw), e) > tol) begin
            n_err++;
            $display("FAIL fcw[%0d]: got %0d, required %0d +-%0d", k, fcw, e, tol);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_axes();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_ena_stall();
`ifdef SGEN_PHASE_DET_FCW_EN
      test_fcw();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sgen_phase_det.md
SGEN_PHASE_DET -- requirements
Module: sgen_phase_det

Interface
REQ-001 SHALL have parameter gp_rom_width, default 8: input magnitude bits; i_sin/i_cos are gp_rom_width+1 bits signed.
REQ-002 SHALL have parameter gp_phase_width, default 16: output phase width; a full circle is 2^gp_phase_width.
REQ-003 SHALL have parameter gp_iterations, default 14: CORDIC micro-rotations, legal range 4..gp_phase_width-2.
REQ-004 SHALL have port i_clk, input, 1: the only clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_an, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_ena, input, 1: global enable; low freezes all state.
REQ-007 SHALL have port i_valid, input, 1: sample strobe for i_sin/i_cos.
REQ-008 SHALL have ports i_sin and i_cos, input, gp_rom_width+1 each: signed quadrature sample (Y, X).
REQ-009 SHALL have port o_ready, output, 1: high when a sample can be accepted.
REQ-010 SHALL have port o_phase, output, gp_phase_width: unsigned phase atan2(i_sin, i_cos), mod 2^gp_phase_width.
REQ-011 SHALL have port o_valid, output, 1: one-cycle result strobe.

Function
REQ-012 SHALL use a three-state FSM: IDLE -> ROTATE on accept; ROTATE -> DONE after gp_iterations cycles; DONE -> IDLE after one cycle.
REQ-013 SHALL accept a sample only when i_ena & i_valid & o_ready; o_ready SHALL be high only in IDLE.
REQ-014 SHALL ignore i_valid asserted outside IDLE; such samples are dropped, not queued.
REQ-015 SHALL pre-rotate at accept: if i_cos<0 then x=-i_cos, y=-i_sin, z=2^(gp_phase_width-1); else x=i_cos, y=i_sin, z=0.
REQ-016 SHALL hold x and y at gp_rom_width+3 bits signed, so that negating the most-negative input and CORDIC gain (≈1.647·√2) cause no overflow.
REQ-017 SHALL perform one micro-rotation per ROTATE cycle i: if y>=0 then x+=y>>>i, y-=x>>>i, z+=atan_i; else x-=y>>>i, y+=x>>>i, z-=atan_i.
REQ-018 SHALL accumulate z modulo 2^gp_phase_width; wrap-around is intended, not saturated.
REQ-019 SHALL update o_phase with z and pulse o_valid in DONE: accept-to-o_valid latency is gp_iterations+1 cycles; a new sample is accepted at the earliest gp_iterations+2 cycles after the previous one.
REQ-020 SHALL hold o_phase between results.
REQ-021 SHALL output o_phase=0 for input (0,0).
REQ-022 SHALL hold FSM, counter, x/y/z and outputs unchanged while i_ena is low; o_valid SHALL NOT pulse while i_ena is low, and the pending result SHALL complete after i_ena returns.

Reset
REQ-023 SHALL, on i_rst_an low, immediately force state=IDLE, iteration counter=0, x/y/z=0, o_phase=0, o_valid=0; o_ready SHALL read 1 after reset release.
REQ-024 SHALL abandon any in-flight computation when reset is asserted mid-ROTATE, with no o_valid pulse for the abandoned sample.

Configuration
REQ-025 SHALL, with SGEN_PHASE_DET_FCW_EN defined, add port o_fcw (output, gp_phase_width) set to o_phase_new - o_phase_prev mod 2^gp_phase_width at each o_valid, reset 0, with the first result after reset giving o_fcw=0.
REQ-026 SHALL, without SGEN_PHASE_DET_FCW_EN, have neither port o_fcw nor the previous-phase register.

Structure
REQ-027 SHALL place the FSM state typedef and the arctangent constant table (atan(2^-i) scaled to 2^gp_phase_width, i=0..gp_phase_width-1) in shared package sgen_pkg.
REQ-028 SHALL place the add/subtract micro-rotation datapath in one sub-module, sgen_cordic_stage, instantiated once and reused across iterations.

Verification
All scenarios use the default parameters, where input max is 255 and the tolerance is ±2 LSB.
REQ-029 SHALL test: (sin=0, cos=255) -> o_phase 0 (or 65534..65535), o_valid 15 cycles after accept.
REQ-030 SHALL test: (255, 0) -> 16384; (0, -256) -> 32768; (-255, 0) -> 49152.
REQ-031 SHALL test: i_valid held high continuously -> one accept every 16 cycles, intermediate samples dropped, o_ready low during ROTATE/DONE.
REQ-032 SHALL test: i_rst_an pulsed low at iteration 5 -> no o_valid, o_phase=0, o_ready=1 on the next edge after release.
REQ-033 SHALL test: i_ena dropped for 10 cycles mid-ROTATE -> latency extended by exactly 10 cycles, result unchanged.
REQ-034 SHALL test, with SGEN_PHASE_DET_FCW_EN, a stream from sgen_nco with FCW 1024 sampled at each o_ready -> o_fcw constant at 16·1024 mod 65536 = 16384 ±2 after the first two results.
